// File: rtl/mux8_pkg.sv
// Shared constants and select type for the map-row word multiplexer.
package mux8_pkg;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned NUM_IN = 8;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux8_sel_reg_if.sv
// Bus bundle for mux8_sel_reg: eight candidate words, select and the three outputs.
interface mux8_sel_reg_if
  import mux8_pkg::*;
#(
  parameter int unsigned WIDTH = 7
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] in4;
  logic [WIDTH-1:0] in5;
  logic [WIDTH-1:0] in6;
  logic [WIDTH-1:0] in7;
  sel_t             sel;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  sel_t             sel_q;

  modport master (
    output in0, in1, in2, in3, in4, in5, in6, in7, sel,
    input  out, out_q, sel_q
  );

  modport slave (
    input  in0, in1, in2, in3, in4, in5, in6, in7, sel,
    output out, out_q, sel_q
  );
endinterface

// File: rtl/mux8_sel_reg_dff_ar_n.sv
// D flip-flop bank with asynchronous active-low clear.
module dff_ar_n #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/mux8_sel_reg.sv
// 8:1 word mux for one map row, with a registered copy of word and select.
// MUX8_OUT_REG_EN: when defined, out is taken from the register (1-cycle latency).
module mux8_sel_reg
  import mux8_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  mux8_sel_reg_if.slave  bus
);
  logic [WIDTH-1:0]       w_sel_word;
  logic [WIDTH+SEL_W-1:0] w_q;
  logic [WIDTH-1:0]       w_out_q;

  always_comb begin
    w_sel_word = '0;
    case (bus.sel)
      3'd0: w_sel_word = bus.in0;
      3'd1: w_sel_word = bus.in1;
      3'd2: w_sel_word = bus.in2;
      3'd3: w_sel_word = bus.in3;
      3'd4: w_sel_word = bus.in4;
      3'd5: w_sel_word = bus.in5;
      3'd6: w_sel_word = bus.in6;
      3'd7: w_sel_word = bus.in7;
    endcase
  end

  // Word and select share one register bank so they always update together.
  dff_ar_n #(
    .W (WIDTH + SEL_W)
  ) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({w_sel_word, bus.sel}),
    .o_q   (w_q)
  );

  assign w_out_q   = w_q[WIDTH+SEL_W-1:SEL_W];
  assign bus.out_q = w_out_q;
  assign bus.sel_q = sel_t'(w_q[SEL_W-1:0]);

`ifdef MUX8_OUT_REG_EN
  assign bus.out = w_out_q;
`else
  assign bus.out = w_sel_word;
`endif
endmodule

// File: tb/tb_mux8_sel_reg.sv
// Directed, table-driven bench for mux8_sel_reg; expectations follow MUX8_OUT_REG_EN.
module tb_mux8_sel_reg;
  import mux8_pkg::*;

  localparam int unsigned W = 7;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mux8_sel_reg_if #(.WIDTH(W)) bus ();

  mux8_sel_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    sel_t         sel;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{3'd0, 7'b0000100};
    vecs[1] = '{3'd1, 7'b1110000};
    vecs[2] = '{3'd2, 7'b1110111};
    vecs[3] = '{3'd3, 7'b0000111};
    vecs[4] = '{3'd4, 7'b0000111};
    vecs[5] = '{3'd5, 7'b1000000};
    vecs[6] = '{3'd6, 7'b0111000};
    vecs[7] = '{3'd7, 7'b1000000};

    bus.in0 = 7'b0000100;
    bus.in1 = 7'b1110000;
    bus.in2 = 7'b1110111;
    bus.in3 = 7'b0000111;
    bus.in4 = 7'b0000111;
    bus.in5 = 7'b1000000;
    bus.in6 = 7'b0111000;
    bus.in7 = 7'b1000000;
    bus.sel = 3'd6;
    rst_n   = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("reset_out_q", 32'(bus.out_q), 32'd0);
    chk("reset_sel_q", 32'(bus.sel_q), 32'd0);
`ifdef MUX8_OUT_REG_EN
    chk("reset_out", 32'(bus.out), 32'd0);
`else
    chk("reset_out_comb", 32'(bus.out), 32'b0111000);
`endif

    @(negedge clk);
    rst_n = 1'b1;

    // Select sweep
    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.sel = vecs[i].sel;
      #1;
`ifndef MUX8_OUT_REG_EN
      chk($sformatf("sweep_out_comb[%0d]", i), 32'(bus.out), 32'(vecs[i].exp));
`endif
      @(posedge clk); #1;
      chk($sformatf("sweep_out_q[%0d]", i), 32'(bus.out_q), 32'(vecs[i].exp));
      chk($sformatf("sweep_sel_q[%0d]", i), 32'(bus.sel_q), 32'(vecs[i].sel));
      chk($sformatf("sweep_out[%0d]", i), 32'(bus.out), 32'(vecs[i].exp));
    end

    // One-cycle latency of the registered copy
    @(negedge clk);
    bus.sel = 3'd3;
    @(posedge clk); #1;
    chk("lat_out_q_3", 32'(bus.out_q), 32'b0000111);
    chk("lat_sel_q_3", 32'(bus.sel_q), 32'd3);
    @(negedge clk);
    bus.sel = 3'd5;
    #1;
    chk("lat_out_q_hold", 32'(bus.out_q), 32'b0000111);
    chk("lat_sel_q_hold", 32'(bus.sel_q), 32'd3);
`ifdef MUX8_OUT_REG_EN
    chk("lat_out_hold", 32'(bus.out), 32'b0000111);
`else
    chk("lat_out_comb", 32'(bus.out), 32'b1000000);
`endif
    @(posedge clk); #1;
    chk("lat_out_q_5", 32'(bus.out_q), 32'b1000000);
    chk("lat_sel_q_5", 32'(bus.sel_q), 32'd5);

    // Asynchronous reset between edges
    @(negedge clk);
    bus.sel = 3'd2;
    rst_n   = 1'b0;
    #1;
    chk("arst_out_q", 32'(bus.out_q), 32'd0);
    chk("arst_sel_q", 32'(bus.sel_q), 32'd0);
`ifdef MUX8_OUT_REG_EN
    chk("arst_out", 32'(bus.out), 32'd0);
`else
    chk("arst_out_comb", 32'(bus.out), 32'b1110111);
`endif
    @(posedge clk); #1;
    chk("arst_hold_out_q", 32'(bus.out_q), 32'd0);
    chk("arst_hold_sel_q", 32'(bus.sel_q), 32'd0);

    // Reset release: first edge loads the selection
    @(negedge clk);
    rst_n   = 1'b1;
    bus.sel = 3'd4;
    #1;
    chk("rel_pre_out_q", 32'(bus.out_q), 32'd0);
    @(posedge clk); #1;
    chk("rel_out_q", 32'(bus.out_q), 32'b0000111);
    chk("rel_sel_q", 32'(bus.sel_q), 32'd4);
    chk("rel_out", 32'(bus.out), 32'b0000111);

    // Data change on the selected input
    @(negedge clk);
    bus.sel = 3'd2;
    @(posedge clk); #1;
    chk("data_out_q_old", 32'(bus.out_q), 32'b1110111);
    @(negedge clk);
    bus.in2 = 7'b0100000;
    #1;
`ifdef MUX8_OUT_REG_EN
    chk("data_out_hold", 32'(bus.out), 32'b1110111);
`else
    chk("data_out_comb", 32'(bus.out), 32'b0100000);
`endif
    chk("data_out_q_hold", 32'(bus.out_q), 32'b1110111);
    @(posedge clk); #1;
    chk("data_out_q_new", 32'(bus.out_q), 32'b0100000);
    chk("data_sel_q", 32'(bus.sel_q), 32'd2);

    // Select 0 -> 7, then reset while out is observed
    @(negedge clk);
    bus.sel = 3'd0;
    @(posedge clk); #1;
    chk("s07_out_0", 32'(bus.out), 32'b0000100);
    @(negedge clk);
    bus.sel = 3'd7;
    #1;
`ifdef MUX8_OUT_REG_EN
    chk("s07_out_hold", 32'(bus.out), 32'b0000100);
`else
    chk("s07_out_comb", 32'(bus.out), 32'b1000000);
`endif
    @(posedge clk); #1;
    chk("s07_out_7", 32'(bus.out), 32'b1000000);
    chk("s07_sel_q", 32'(bus.sel_q), 32'd7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
`ifdef MUX8_OUT_REG_EN
    chk("s07_rst_out", 32'(bus.out), 32'd0);
`else
    chk("s07_rst_out_comb", 32'(bus.out), 32'b1000000);
`endif
    chk("s07_rst_out_q", 32'(bus.out_q), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
